mul_logic_pipe: RTL and testbench
=================================

MUL_LOGIC_PIPE -- requirements
Module: mul_logic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width (legal range 2..32).
REQ-002 SHALL have parameter STAGES, default 1, pipeline depth in register stages (legal range 1..4).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning a, b, c and op are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an input this cycle.
REQ-007 SHALL have port a, input, WIDTH, multiplicand.
REQ-008 SHALL have port b, input, WIDTH, multiplier.
REQ-009 SHALL have port c, input, WIDTH, second operand of the combine step.
REQ-010 SHALL have port op, input, 2, combine mode: 00 OR, 01 AND, 10 XOR, 11 ADD.
REQ-011 SHALL have port p, output, WIDTH, result.
REQ-012 SHALL have port out_valid, output, 1, meaning p holds a valid result.
REQ-013 SHALL have port out_ready, input, 1, meaning the downstream accepts p this cycle.

Function
REQ-014 SHALL compute m = (a * b) mod 2^WIDTH, i.e. the low WIDTH bits of the full 2*WIDTH-bit product.
REQ-015 SHALL produce r = m | c, m & c, m ^ c, or (m + c) mod 2^WIDTH for op 00, 01, 10 and 11 respectively; ADD carry-out is discarded.
REQ-016 SHALL capture op together with a, b and c at acceptance; later changes to op SHALL NOT affect in-flight items.
REQ-017 SHALL accept a transfer on a rising edge when in_valid && in_ready.
REQ-018 SHALL define advance = !out_valid || out_ready; in_ready SHALL equal advance, combinationally.
REQ-019 SHALL hold all STAGES data registers and valid bits unchanged when advance is 0 (global stall).
REQ-020 SHALL shift every stage forward by one when advance is 1; stage 0 valid SHALL load in_valid.
REQ-021 SHALL propagate bubbles (invalid slots) without collapsing them.
REQ-022 SHALL present a result accepted at edge N on p with out_valid=1 after edge N+STAGES-1, i.e. visible in the cycle following edge N+STAGES-1, when no stall occurs; latency SHALL be STAGES cycles and throughput one item per cycle.
REQ-023 SHALL drive p and out_valid directly from the last stage register, with no combinational path from a, b, c or op.
REQ-024 SHALL hold p stable while out_valid && !out_ready.
REQ-025 SHALL let the downstream consume the last item and the upstream insert a new item on the same edge when out_valid, out_ready and in_valid are all 1.
REQ-026 SHALL pipeline the multiply for STAGES>=2 (product registered before the combine); the exact split SHALL NOT change the results.

Reset
REQ-027 SHALL, on any edge with rst=1, clear all valid bits, set p=0, and set out_valid=0, regardless of in_valid or out_ready.
REQ-028 SHALL discard all in-flight items on mid-operation reset; no pre-reset result SHALL appear afterwards.
REQ-029 SHALL drive in_ready=1 during and immediately after reset, since out_valid is 0.

Verification (WIDTH=16; STAGES=1 and STAGES=3 both run)
REQ-030 SHALL cover OR mode: a=3, b=5, c=16'h00F0, op=00 -> p=16'h00FF, out_valid high STAGES cycles after acceptance.
REQ-031 SHALL cover modes with back-to-back inputs: (16'h00FF, 1, 16'h000F, AND), (16'h1234, 1, 16'hFFFF, XOR), (16'h0100, 16'h0100, 5, ADD) on consecutive cycles -> p=16'h000F, 16'hEDCB, 16'h0005 on consecutive cycles.
REQ-032 SHALL cover stall: hold out_ready=0 for 4 cycles with the pipeline full -> p and out_valid unchanged, in_ready=0, no loss or duplication; release -> results drain in order.
REQ-033 SHALL cover reset mid-operation: assert rst for 1 cycle with 2 items in flight -> out_valid=0 and p=0 after that edge, and neither item ever emerges.
REQ-034 SHALL cover bubbles and wrap: alternate in_valid 1/0 with a=b=16'hFFFF, c=0, op=11 -> p=16'h0001 on alternate cycles, out_valid pattern matching the input pattern.
REQ-035 SHALL cover a random scoreboard: 10000 random transactions with random in_valid/out_ready, compared against the REQ-014/015 model.

Source files
------------

// File: rtl/mul_logic_pipe.sv
// Multiply-then-combine pipeline: p = (a*b mod 2^WIDTH) op c, STAGES register stages deep,
// with valid/ready handshaking and a global stall whenever the output is held.
module mul_logic_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] p,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  // Combine step; ADD wraps because the sum is truncated to WIDTH bits
  function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] m,
                                               input logic [WIDTH-1:0] cv,
                                               input logic [1:0]       mode);
    logic [WIDTH-1:0] r;
    case (mode)
      OP_OR:   r = m | cv;
      OP_AND:  r = m & cv;
      OP_XOR:  r = m ^ cv;
      default: r = m + cv;
    endcase
    return r;
  endfunction

  logic [STAGES-1:0] vld_q;
  logic              advance;
  logic [WIDTH-1:0]  m_c;

  assign advance   = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign m_c       = a * b;

  // Valid bits shift as one with the data; bubbles travel as zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < int'(STAGES); i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  if (STAGES == 1) begin : g_single
    logic [WIDTH-1:0] res_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        res_q <= '0;
      end else if (advance) begin
        res_q <= combine(m_c, c, op);
      end
    end

    assign p = res_q;
  end else begin : g_multi
    // Stage 0 holds the truncated product with its captured c/op; combine happens into stage 1
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] c_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] res_q [1:STAGES-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        m_q  <= '0;
        c_q  <= '0;
        op_q <= '0;
        for (int i = 1; i < int'(STAGES); i++) begin
          res_q[i] <= '0;
        end
      end else if (advance) begin
        m_q      <= m_c;
        c_q      <= c;
        op_q     <= op;
        res_q[1] <= combine(m_q, c_q, op_q);
        for (int i = 2; i < int'(STAGES); i++) begin
          res_q[i] <= res_q[i-1];
        end
      end
    end

    assign p = res_q[STAGES-1];
  end

endmodule

// File: tb/tb_mul_logic_pipe.sv
// Self-checking bench: directed scenarios on a 3-stage and a 1-stage instance sharing stimulus,
// plus a reference-model scoreboard per instance.
module tb_mul_logic_pipe;

  localparam int unsigned W  = 16;
  localparam int          S3 = 3;
  localparam int          S1 = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] a, b, c;
  logic [1:0]   op;
  logic         r1, r3, v1, v3;
  logic [W-1:0] p1, p3;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q3[$];
  logic [W-1:0] e1, e3;

  always #5 clk = ~clk;

  mul_logic_pipe #(.WIDTH(W), .STAGES(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r3),
    .a(a), .b(b), .c(c), .op(op), .p(p3), .out_valid(v3), .out_ready(out_ready)
  );

  mul_logic_pipe #(.WIDTH(W), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1),
    .a(a), .b(b), .c(c), .op(op), .p(p1), .out_valid(v1), .out_ready(out_ready)
  );

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] z, input logic [1:0] mode);
    logic [2*W-1:0] full;
    logic [W-1:0]   m;
    full = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    m    = full[W-1:0];
    case (mode)
      2'b00:   return m | z;
      2'b01:   return m & z;
      2'b10:   return m ^ z;
      default: return W'(m + z);
    endcase
  endfunction

  // Scoreboards: inputs and out_ready are stable at the falling edge
  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      q3.delete();
    end else begin
      if (v3 && out_ready) begin
        checks++;
        if (q3.size() == 0) begin
          errors++;
          $display("FAIL sb_s3 unexpected output p=%h", p3);
        end else begin
          e3 = q3.pop_front();
          if (p3 !== e3) begin
            errors++;
            $display("FAIL sb_s3 p=%h expected %h", p3, e3);
          end
        end
      end
      if (v1 && out_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb_s1 unexpected output p=%h", p1);
        end else begin
          e1 = q1.pop_front();
          if (p1 !== e1) begin
            errors++;
            $display("FAIL sb_s1 p=%h expected %h", p1, e1);
          end
        end
      end
      if (in_valid && r3) q3.push_back(model(a, b, c, op));
      if (in_valid && r1) q1.push_back(model(a, b, c, op));
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] z, input logic [1:0] mode);
    in_valid = v;
    a        = x;
    b        = y;
    c        = z;
    op       = mode;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'h0003, 16'h0003, 16'h0000, 2'b11);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({v3, p3, r3} !== {1'b0, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL reset_s3 valid/p/ready=%b/%h/%b expected 0/0000/1", v3, p3, r3);
    end
    checks++;
    if ({v1, p1, r1} !== {1'b0, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL reset_s1 valid/p/ready=%b/%h/%b expected 0/0000/1", v1, p1, r1);
    end
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 2'b00);
    rst = 1'b0;
  endtask

  task automatic test_or();
    for (int t = 0; t <= S3 + 1; t++) begin
      if (t == 0) drive(1'b1, 16'd3, 16'd5, 16'h00F0, 2'b00);
      else        drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 2'b11);
      @(posedge clk); #1;
      checks++;
      if (v3 !== (t == S3 - 1) || (t == S3 - 1 && p3 !== 16'h00FF)) begin
        errors++;
        $display("FAIL or_s3 t=%0d valid=%b p=%h expected valid=%b p=00ff", t, v3, p3, t == S3 - 1);
      end
      checks++;
      if (v1 !== (t == S1 - 1) || (t == S1 - 1 && p1 !== 16'h00FF)) begin
        errors++;
        $display("FAIL or_s1 t=%0d valid=%b p=%h expected valid=%b p=00ff", t, v1, p1, t == S1 - 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ia[3], ib[3], ic[3], ex[3];
    logic [1:0]   io[3];
    int j;
    ia = '{16'h00FF, 16'h1234, 16'h0100};
    ib = '{16'h0001, 16'h0001, 16'h0100};
    ic = '{16'h000F, 16'hFFFF, 16'h0005};
    io = '{2'b01, 2'b10, 2'b11};
    ex = '{16'h000F, 16'hEDCB, 16'h0005};
    for (int t = 0; t <= S3 + 3; t++) begin
      if (t < 3) drive(1'b1, ia[t], ib[t], ic[t], io[t]);
      else       drive(1'b0, 16'hAAAA, 16'h5555, 16'h0000, 2'b00);
      @(posedge clk); #1;
      j = t - (S3 - 1);
      checks++;
      if (v3 !== (j >= 0 && j < 3) || (j >= 0 && j < 3 && p3 !== ex[j])) begin
        errors++;
        $display("FAIL b2b_s3 t=%0d valid=%b p=%h", t, v3, p3);
      end
      j = t - (S1 - 1);
      checks++;
      if (v1 !== (j >= 0 && j < 3) || (j >= 0 && j < 3 && p1 !== ex[j])) begin
        errors++;
        $display("FAIL b2b_s1 t=%0d valid=%b p=%h", t, v1, p1);
      end
    end
  endtask

  task automatic test_stall();
    // Items i: a=i+1, b=2, c=0, ADD -> p = 2*(i+1)
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      drive(1'b1, W'(t + 1), 16'd2, 16'd0, 2'b11);
      @(posedge clk); #1;
    end
    drive(1'b1, 16'd6, 16'd2, 16'd0, 2'b11);
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      checks++;
      if ({v3, p3, r3} !== {1'b1, 16'd6, 1'b0}) begin
        errors++;
        $display("FAIL stall_s3 t=%0d valid/p/ready=%b/%h/%b expected 1/0006/0", t, v3, p3, r3);
      end
      checks++;
      if ({v1, p1, r1} !== {1'b1, 16'd10, 1'b0}) begin
        errors++;
        $display("FAIL stall_s1 t=%0d valid/p/ready=%b/%h/%b expected 1/000a/0", t, v1, p1, r1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 16'd0, 16'd0, 16'd0, 2'b00);
    checks++;
    if ({v3, p3, v1, p1} !== {1'b1, 16'd8, 1'b1, 16'd12}) begin
      errors++;
      $display("FAIL drain0 s3=%b/%h s1=%b/%h expected 1/0008 1/000c", v3, p3, v1, p1);
    end
    @(posedge clk); #1;
    checks++;
    if ({v3, p3, v1} !== {1'b1, 16'd10, 1'b0}) begin
      errors++;
      $display("FAIL drain1 s3=%b/%h s1 valid=%b expected 1/000a 0", v3, p3, v1);
    end
    @(posedge clk); #1;
    checks++;
    if ({v3, p3} !== {1'b1, 16'd12}) begin
      errors++;
      $display("FAIL drain2 s3=%b/%h expected 1/000c", v3, p3);
    end
    @(posedge clk); #1;
    checks++;
    if (v3 !== 1'b0) begin
      errors++;
      $display("FAIL drain3 s3 valid=%b expected 0", v3);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, 16'd7, 16'd7, 16'd0, 2'b11);
    @(posedge clk); #1;
    drive(1'b1, 16'd9, 16'd9, 16'd0, 2'b11);
    @(posedge clk); #1;
    drive(1'b0, 16'd0, 16'd0, 16'd0, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({v3, p3, r3, v1, p1, r1} !== {1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid s3=%b/%h/%b s1=%b/%h/%b expected 0/0000/1", v3, p3, r3, v1, p1, r1);
    end
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      checks++;
      if (v3 !== 1'b0 || v1 !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_leak t=%0d valid s3=%b s1=%b expected 0", t, v3, v1);
      end
    end
  endtask

  task automatic test_bubbles();
    int j;
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (t < 8 && t % 2 == 0) drive(1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 2'b11);
      else                     drive(1'b0, 16'h1111, 16'h2222, 16'h3333, 2'b00);
      @(posedge clk); #1;
      j = t - (S3 - 1);
      checks++;
      if (v3 !== (j >= 0 && j < 8 && j % 2 == 0) || (v3 && p3 !== 16'h0001)) begin
        errors++;
        $display("FAIL bubble_s3 t=%0d valid=%b p=%h", t, v3, p3);
      end
      j = t - (S1 - 1);
      checks++;
      if (v1 !== (j >= 0 && j < 8 && j % 2 == 0) || (v1 && p1 !== 16'h0001)) begin
        errors++;
        $display("FAIL bubble_s1 t=%0d valid=%b p=%h", t, v1, p1);
      end
    end
  endtask

  task automatic test_random();
    int acc = 0;
    int cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      drive(($urandom_range(0, 9) < 7), W'($urandom), W'($urandom), W'($urandom), 2'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_valid && r3) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (acc < 10000) begin
      errors++;
      $display("FAIL random_budget accepted=%0d expected 10000", acc);
    end
    drive(1'b0, 16'd0, 16'd0, 16'd0, 2'b00);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL random_drain pending s1=%0d s3=%0d expected 0", q1.size(), q3.size());
    end
  endtask

  initial begin
    test_reset();
    test_or();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_bubbles();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
